stack_alu_seq: RTL
==================

Name: stack_alu_seq

Overview:
- Initiator on the operand-stack pop/push interface: accepts one opcode at a time, pops operands via the stack's ALU pop strobe, computes, and pushes the result back.
- Sits between the instruction decode and the 16-deep, 32-bit operand stack.
- Tracks stack depth itself (the stack exposes no pointer), so it can refuse underflow and overflow before touching the stack.

Parameters:
- DEPTH, 16, stack capacity in words; the depth counter is clog2(DEPTH)+1 bits wide.
- WIDTH, 32, data width.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  opcode offered.
- op_code  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 DUP, 7 MUL (optional).
- op_ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse: op completed successfully.
- err  out  1  one-cycle pulse: op rejected (underflow, full, illegal).
- result  out  WIDTH  last pushed result; held until the next done.
- flag_z, flag_c, flag_v  out  1 each  flags of the last result; held.
- stk_top  in  WIDTH  top-of-stack value from the stack, combinational, 0 when empty.
- stk_pop_alu, stk_push, stk_enable  out  1 each  stack strobes.
- stk_data  out  WIDTH  push data.
- host_push, host_pop  in  1 each  observed strobes from other stack masters; used only for depth tracking.
- depth  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- depth_err  out  1  sticky; set by a host push while full or a host pop while empty.

Behaviour:
- Reset:
  - State goes to IDLE.
  - depth, result, flags, depth_err, done, err and all stk_* outputs go to 0.
  - Reset mid-operation abandons the op without pushing. Operands already popped are lost, and depth still reflects the pops already issued before it is zeroed.
- FSM states: IDLE, POP_B, POP_A, EXEC, PUSH.
- IDLE:
  - When op_valid is high, the op is checked at that edge.
  - Binary ops (0-4, 7) need depth>=2. NOT needs depth>=1. DUP needs 1<=depth<DEPTH.
  - On a failed check, err pulses the next cycle, with no stack strobe and no state change.
  - Binary ops go to POP_B. NOT goes to POP_A. DUP goes to EXEC.
- POP_B:
  - Latch B=stk_top.
  - Assert stk_pop_alu and stk_enable for exactly this cycle.
- POP_A:
  - Latch A=stk_top, which now shows the next entry.
  - Assert stk_pop_alu and stk_enable.
- EXEC:
  - Compute R; DUP latches R=stk_top.
  - No strobes.
- PUSH:
  - stk_push=1, stk_enable=1, stk_data=R.
  - done=1, result=R, and flags are updated at the end of this cycle.
  - Return to IDLE.
- Latency:
  - Binary op: accepted at edge 0, stk_push/done high in cycle 4.
  - NOT: cycle 3.
  - DUP: cycle 2.
  - Next op is accepted the cycle after done.
- Stack strobes:
  - push and pop are never asserted in the same cycle.
  - stk_enable is high only when a strobe is high.
- Arithmetic, all on WIDTH bits modulo 2^WIDTH:
  - SUB = A-B, where A is the deeper operand.
  - NOT = ~A.
  - flag_z = (R==0).
  - flag_c: carry-out for ADD, borrow for SUB (A<B unsigned), 0 for logic ops and DUP.
  - flag_v: signed overflow for ADD/SUB, else 0.
- Depth update per cycle: depth += own push + host_push - own pop - host_pop.
  - Saturates at 0 and DEPTH.
  - A saturating host event sets depth_err.
  - Host strobes during a sequencer op are counted, but the result ordering is undefined; the hosts must not drive the stack while op_ready is 0.

Optional Feature:
- Macro STACK_ALU_MUL_EN.
- Defined: opcode 7 is MUL.
  - R = low WIDTH bits of the unsigned product A*B.
  - flag_c = |(high WIDTH bits).
  - flag_v = 0.
  - Same latency as ADD; the multiply is combinational in EXEC.
- Undefined: opcode 7 is illegal and gives an err pulse from IDLE with no stack activity.

Test Plan:
- Host pushes 5 then 7, ADD -> two stk_pop_alu cycles, stk_push with 12 in cycle 4, done=1, depth=1, flag_z=0, flag_c=0.
- Pushes 3 then 5, SUB -> result 0xFFFFFFFE, flag_c=1, flag_v=0; then push 0x7FFFFFFF and 1, ADD -> 0x80000000, flag_v=1.
- depth=1, ADD -> err pulse, no strobes, depth stays 1. depth=16, DUP -> err. depth=15, DUP of 9 -> two entries of 9, depth=16.
- Push 0xFFFF0000, NOT -> 0x0000FFFF after one pop, push in cycle 3. Push 0 and 0, XOR -> flag_z=1.
- Reset asserted in the POP_A cycle of an ADD with depth 2 -> next cycle IDLE, depth=0, no push, done=0, result=0.
- MUL of 0x10000 by 0x10000 -> with STACK_ALU_MUL_EN, result=0, flag_c=1. Without it, err pulse and depth unchanged at 2.

Source files
------------

// File: rtl/stack_alu_seq.sv
// Sequencer that pops operands from the operand stack, runs one ALU op, and pushes the result back.
// Optional MUL on opcode 7 is enabled by defining STACK_ALU_MUL_EN.
module stack_alu_seq #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int DW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  output logic             op_ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  input  logic [WIDTH-1:0] stk_top,
  output logic             stk_pop_alu,
  output logic             stk_push,
  output logic             stk_enable,
  output logic [WIDTH-1:0] stk_data,
  input  logic             host_push,
  input  logic             host_pop,
  output logic [DW-1:0]    depth,
  output logic             depth_err,
  output logic [2:0]       state_dbg
);

  // Handshake: an op transfers on a rising edge where op_valid && op_ready;
  // op_ready is high only in IDLE, and the op is checked on that same edge.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP_B = 3'd1;
  localparam logic [2:0] S_POP_A = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_PUSH  = 3'd4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_DUP = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
  localparam logic [DW-1:0] DEPTH_TWO = DW'(2);

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             pz_q, pz_d;
  logic             pc_q, pc_d;
  logic             pv_q, pv_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_v_q, flag_v_d;
  logic             err_q, err_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             depth_err_q, depth_err_d;

  logic             op_legal;
  logic [2:0]       idle_next;

  logic [WIDTH-1:0] alu_r;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   sum_ext;
`ifdef STACK_ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif

  logic [1:0]       inc_cnt;
  logic [1:0]       dec_cnt;
  logic [DW:0]      depth_up;
  logic [DW:0]      depth_net;

  // Admission check against the tracked depth, before any stack strobe.
  always_comb begin
    op_legal  = 1'b0;
    idle_next = S_IDLE;
    case (op_code)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        op_legal  = (depth_q >= DEPTH_TWO);
        idle_next = S_POP_B;
      end
      OP_NOT: begin
        op_legal  = (depth_q >= DEPTH_ONE);
        idle_next = S_POP_A;
      end
      OP_DUP: begin
        op_legal  = (depth_q >= DEPTH_ONE) && (depth_q < DEPTH_MAX);
        idle_next = S_EXEC;
      end
      OP_MUL: begin
`ifdef STACK_ALU_MUL_EN
        op_legal  = (depth_q >= DEPTH_TWO);
        idle_next = S_POP_B;
`else
        op_legal  = 1'b0;
        idle_next = S_IDLE;
`endif
      end
      default: begin
        op_legal  = 1'b0;
        idle_next = S_IDLE;
      end
    endcase
  end

  // A is the deeper operand, B the former top of stack.
  always_comb begin
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_ext = {1'b0, a_q} + {1'b0, b_q};
`ifdef STACK_ALU_MUL_EN
    prod    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif
    case (op_q)
      OP_ADD: begin
        alu_r = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
        alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_r[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = a_q - b_q;
        alu_c = (a_q < b_q);
        alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_r[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_r = a_q & b_q;
      OP_OR:  alu_r = a_q | b_q;
      OP_XOR: alu_r = a_q ^ b_q;
      OP_NOT: alu_r = ~a_q;
      OP_DUP: alu_r = stk_top;
`ifdef STACK_ALU_MUL_EN
      OP_MUL: begin
        alu_r = prod[WIDTH-1:0];
        alu_c = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: alu_r = '0;
    endcase
    alu_z = (alu_r == '0);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    pz_d     = pz_q;
    pc_d     = pc_q;
    pv_d     = pv_q;
    result_d = result_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (op_legal) begin
            op_d    = op_code;
            state_d = idle_next;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      S_POP_B: begin
        b_d     = stk_top;
        state_d = S_POP_A;
      end
      S_POP_A: begin
        a_d     = stk_top;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        r_d     = alu_r;
        pz_d    = alu_z;
        pc_d    = alu_c;
        pv_d    = alu_v;
        state_d = S_PUSH;
      end
      S_PUSH: begin
        result_d = r_q;
        flag_z_d = pz_q;
        flag_c_d = pc_q;
        flag_v_d = pv_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stk_pop_alu = (state_q == S_POP_B) || (state_q == S_POP_A);
    stk_push    = (state_q == S_PUSH);
    stk_enable  = stk_pop_alu || stk_push;
    stk_data    = stk_push ? r_q : '0;
    done        = (state_q == S_PUSH);
    op_ready    = (state_q == S_IDLE);
  end

  // Depth counts our own strobes plus observed host strobes; only host events flag saturation.
  always_comb begin
    inc_cnt     = {1'b0, stk_push} + {1'b0, host_push};
    dec_cnt     = {1'b0, stk_pop_alu} + {1'b0, host_pop};
    depth_up    = {1'b0, depth_q} + {{(DW-1){1'b0}}, inc_cnt};
    depth_net   = '0;
    depth_d     = depth_q;
    depth_err_d = depth_err_q;
    if (depth_up < {{(DW-1){1'b0}}, dec_cnt}) begin
      depth_d     = '0;
      depth_err_d = depth_err_q | host_pop;
    end else begin
      depth_net = depth_up - {{(DW-1){1'b0}}, dec_cnt};
      if (depth_net > {1'b0, DEPTH_MAX}) begin
        depth_d     = DEPTH_MAX;
        depth_err_d = depth_err_q | host_push;
      end else begin
        depth_d     = depth_net[DW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      pz_q        <= 1'b0;
      pc_q        <= 1'b0;
      pv_q        <= 1'b0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      err_q       <= 1'b0;
      depth_q     <= '0;
      depth_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      r_q         <= r_d;
      pz_q        <= pz_d;
      pc_q        <= pc_d;
      pv_q        <= pv_d;
      result_q    <= result_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      flag_v_q    <= flag_v_d;
      err_q       <= err_d;
      depth_q     <= depth_d;
      depth_err_q <= depth_err_d;
    end
  end

  assign result    = result_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;
  assign err       = err_q;
  assign depth     = depth_q;
  assign depth_err = depth_err_q;
  assign state_dbg = state_q;

endmodule
